// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory bus bundle for the data memory arbiter
//
// Purpose: groups requester A (load/store), requester B (weight-fetch bursts)
// and the single-port data memory pins into one interface.
// Modports:
//   slave  - arbiter side: samples requests and mem_rdata, drives grants,
//            responses, memory pins and busy.
//   master - environment side: requesters and memory.
// Signals:
//   a_req/a_we/a_addr/a_wdata -> ; a_gnt/a_rvalid/a_rdata <-
//   b_req/b_addr/b_len -> ; b_gnt/b_rvalid/b_rdata/b_done <-
//   mem_writeEn/mem_readEn/mem_addr/mem_wdata <- ; mem_rdata ->
//   busy <-

interface dmem_arbiter_if #(
    parameter int IN_BUS_WIDTH    = 32,
    parameter int MEMORY_WIDTH    = 32,
    parameter int BURST_LEN_WIDTH = 8
);
    logic                       a_req;
    logic                       a_we;
    logic [IN_BUS_WIDTH-1:0]    a_addr;
    logic [MEMORY_WIDTH-1:0]    a_wdata;
    logic                       a_gnt;
    logic                       a_rvalid;
    logic [MEMORY_WIDTH-1:0]    a_rdata;

    logic                       b_req;
    logic [IN_BUS_WIDTH-1:0]    b_addr;
    logic [BURST_LEN_WIDTH-1:0] b_len;
    logic                       b_gnt;
    logic                       b_rvalid;
    logic [MEMORY_WIDTH-1:0]    b_rdata;
    logic                       b_done;

    logic                       mem_writeEn;
    logic                       mem_readEn;
    logic [IN_BUS_WIDTH-1:0]    mem_addr;
    logic [MEMORY_WIDTH-1:0]    mem_wdata;
    logic [MEMORY_WIDTH-1:0]    mem_rdata;

    logic                       busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_addr, b_len,
        output b_gnt, b_rvalid, b_rdata, b_done,
        output mem_writeEn, mem_readEn, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_addr, b_len,
        input  b_gnt, b_rvalid, b_rdata, b_done,
        input  mem_writeEn, mem_readEn, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter in front of a single-port data memory
//
// Purpose: shares one combinational-read data memory between requester A
// (single-word loads/stores, fixed higher priority) and requester B
// (read-only bursts). Read data is registered before being returned.
// Ports:
//   CLK  - clock, everything on posedge
//   RST  - synchronous active-high reset
//   bus  - dmem_arbiter_if.slave: A/B request+response channels, memory pins, busy
// Configuration:
//   DMEM_ARB_PREEMPT_EN - when defined, an A request pauses a running burst for
//                         one A access, after which the burst resumes in place.

module dmem_arbiter #(
    parameter int IN_BUS_WIDTH    = 32,
    parameter int MEMORY_WIDTH    = 32,
    parameter int BURST_LEN_WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    dmem_arbiter_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, A_ACC, B_LOAD, B_BURST} state_t;

    state_t                     state_q,    state_d;
    logic                       resume_q,   resume_d;   // A_ACC returns into B_BURST
    logic [IN_BUS_WIDTH-1:0]    addr_q,     addr_d;
    logic [BURST_LEN_WIDTH-1:0] cnt_q,      cnt_d;
    logic                       a_rvalid_q, a_rvalid_d;
    logic [MEMORY_WIDTH-1:0]    a_rdata_q,  a_rdata_d;
    logic                       b_rvalid_q, b_rvalid_d;
    logic [MEMORY_WIDTH-1:0]    b_rdata_q,  b_rdata_d;
    logic                       b_done_q,   b_done_d;

    always_comb begin
        state_d         = state_q;
        resume_d        = resume_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        a_rvalid_d      = 1'b0;
        a_rdata_d       = a_rdata_q;
        b_rvalid_d      = 1'b0;
        b_rdata_d       = b_rdata_q;
        b_done_d        = 1'b0;
        bus.a_gnt       = 1'b0;
        bus.b_gnt       = 1'b0;
        bus.mem_writeEn = 1'b0;
        bus.mem_readEn  = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;

        case (state_q)
            IDLE: begin
                resume_d = 1'b0;
                if (bus.a_req) begin
                    state_d = A_ACC;
                end else if (bus.b_req) begin
                    state_d = B_LOAD;
                end
            end

            A_ACC: begin
                bus.a_gnt    = 1'b1;
                bus.mem_addr = bus.a_addr;
                if (bus.a_we) begin
                    bus.mem_writeEn = 1'b1;
                    bus.mem_wdata   = bus.a_wdata;
                end else begin
                    bus.mem_readEn = 1'b1;
                    a_rvalid_d     = 1'b1;
                    a_rdata_d      = bus.mem_rdata;
                end
                // a_req is still the request just served, so only B can be
                // arbitrated here; this lets a waiting B be granted right away.
                resume_d = 1'b0;
                if (resume_q) begin
                    state_d = B_BURST;
                end else if (bus.b_req) begin
                    state_d = B_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end

            B_LOAD: begin
                bus.b_gnt = 1'b1;
                addr_d    = bus.b_addr;
                cnt_d     = bus.b_len;
                if (bus.b_len == '0) begin
                    b_done_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = B_BURST;
                end
            end

            B_BURST: begin
                bus.mem_readEn = 1'b1;
                bus.mem_addr   = addr_q;
                addr_d         = addr_q + IN_BUS_WIDTH'(1);
                cnt_d          = cnt_q - BURST_LEN_WIDTH'(1);
                b_rvalid_d     = 1'b1;
                b_rdata_d      = bus.mem_rdata;
                if (cnt_q == BURST_LEN_WIDTH'(1)) begin
                    b_done_d = 1'b1;
                    state_d  = IDLE;
                end
`ifdef DMEM_ARB_PREEMPT_EN
                // The word read this cycle still completes; the pause starts
                // next cycle with addr/cnt already pointing at the next word.
                if (bus.a_req) begin
                    state_d  = A_ACC;
                    resume_d = (cnt_q != BURST_LEN_WIDTH'(1));
                end
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            resume_q   <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            a_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rvalid_q <= 1'b0;
            b_rdata_q  <= '0;
            b_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            a_rvalid_q <= a_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rvalid_q <= b_rvalid_d;
            b_rdata_q  <= b_rdata_d;
            b_done_q   <= b_done_d;
        end
    end

    assign bus.a_rvalid = a_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.b_done   = b_done_q;
    assign bus.busy     = (state_q != IDLE);
endmodule
